// File: rtl/wu_fetch_sequencer.sv
// Work-Unit fetch sequencer: credit-limited reads of WU memory into a small
// descriptor FIFO, end-of-WU detection, over-fetch discard and completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; stale memory returns are ignored
// S_FETCH | issuing reads while FIFO occupancy + outstanding < depth
// S_DRAIN | no reads; waiting for outstanding returns and FIFO to empty
// S_DONE  | one-cycle completion pulse, then back to idle
module wu_fetch_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              mcntl__wusq__start,
    input  logic [ADDR_W-1:0] mcntl__wusq__start_addr,
    input  logic              mcntl__wusq__abort,
    output logic              wusq__mcntl__busy,
    output logic              wusq__mcntl__done,
    output logic              wusq__wum__read,
    output logic [ADDR_W-1:0] wusq__wum__addr,
    input  logic              wum__wusq__valid,
    input  logic [DATA_W-1:0] wum__wusq__data,
    output logic              wusq__dec__valid,
    output logic [DATA_W-1:0] wusq__dec__data,
    input  logic              dec__wusq__ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_discard;
    logic                w_discard_nxt;
    logic [ADDR_W-1:0]   r_addr_cnt;
    logic [CNT_W-1:0]    r_out;
    logic [CNT_W-1:0]    r_occ;
    logic [CNT_W-1:0]    w_out_nxt;
    logic [CNT_W-1:0]    w_occ_nxt;
    logic [CNT_W-1:0]    w_credit;
    logic                r_busy;
    logic                r_done;
    logic                r_read;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;

    logic                w_active;
    logic                w_start;
    logic                w_abort;
    logic                w_ret;
    logic                w_wr;
    logic                w_wr_last;
    logic                w_pop;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic                w_drain_done;

    assign w_active  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_start   = mcntl__wusq__start && (r_state == S_IDLE);
    assign w_abort   = mcntl__wusq__abort && w_active;
    assign w_ret     = wum__wusq__valid && w_active;
    assign w_wr      = w_ret && !r_discard && !w_abort;
    assign w_wr_last = w_wr && wum__wusq__data[DATA_W-1];
    assign w_pop     = wusq__dec__valid && dec__wusq__ready;
    // A pop this cycle frees a slot before any new read's data can arrive.
    assign w_credit  = r_occ + r_out - {{PTR_W{1'b0}}, w_pop};

    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = r_addr_cnt;
        if (w_start) begin
            w_issue      = 1'b1;
            w_issue_addr = mcntl__wusq__start_addr;
        end else if ((r_state == S_FETCH) && !w_abort && (w_credit < DEPTH_C)) begin
            w_issue = 1'b1;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ + {{PTR_W{1'b0}}, w_wr} - {{PTR_W{1'b0}}, w_pop};
        if (w_abort) begin
            w_occ_nxt = '0;
        end
        w_out_nxt = r_out + {{PTR_W{1'b0}}, w_issue} - {{PTR_W{1'b0}}, w_ret};
        if (r_state == S_IDLE) begin
            w_out_nxt = {{PTR_W{1'b0}}, w_issue};
        end
    end

    assign w_drain_done = (w_out_nxt == '0) && (w_occ_nxt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt   = S_FETCH;
                    w_discard_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                if (w_abort) begin
                    w_discard_nxt = 1'b1;
                    // Nothing in flight: the drain is already complete.
                    w_state_nxt   = w_drain_done ? S_DONE : S_DRAIN;
                end else if (w_wr_last) begin
                    w_discard_nxt = 1'b1;
                    w_state_nxt   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    w_discard_nxt = 1'b1;
                end
                if (w_drain_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state    <= S_IDLE;
            r_discard  <= 1'b0;
            r_addr_cnt <= '0;
            r_out      <= '0;
            r_occ      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_read     <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            r_out     <= w_out_nxt;
            r_occ     <= w_occ_nxt;
            r_busy    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
            r_done    <= (w_state_nxt == S_DONE);
            r_read    <= w_issue;
            if (w_issue) begin
                r_addr     <= w_issue_addr;
                r_addr_cnt <= w_issue_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            // Credit accounting must make a write into a full FIFO impossible.
            assert (!(w_wr && !w_pop && (r_occ == DEPTH_C)));
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) begin
                    r_fifo[r_wr_ptr] <= wum__wusq__data;
                    r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign wusq__mcntl__busy = r_busy;
    assign wusq__mcntl__done = r_done;
    assign wusq__wum__read   = r_read;
    assign wusq__wum__addr   = r_addr;
    assign wusq__dec__valid  = (r_occ != '0);
    assign wusq__dec__data   = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_wu_fetch_sequencer.sv
// Scoreboard bench for wu_fetch_sequencer: expected reads and decoder words are
// queued by the stimulus and checked by a negedge monitor; memory is modelled.
module tb_wu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_poweron = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        rd;
    logic [9:0]  rd_addr;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic        dvalid;
    logic [31:0] ddata;
    logic        dready = 1'b0;

    always #5 clk = ~clk;

    wu_fetch_sequencer #(.ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk                     (clk),
        .reset_poweron           (reset_poweron),
        .mcntl__wusq__start      (start),
        .mcntl__wusq__start_addr (start_addr),
        .mcntl__wusq__abort      (abort),
        .wusq__mcntl__busy       (busy),
        .wusq__mcntl__done       (done),
        .wusq__wum__read         (rd),
        .wusq__wum__addr         (rd_addr),
        .wum__wusq__valid        (wvalid),
        .wum__wusq__data         (wdata),
        .wusq__dec__valid        (dvalid),
        .wusq__dec__data         (ddata),
        .dec__wusq__ready        (dready)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned c0 = 0;
    int          lat = 1;
    int          done_cnt = 0;
    int unsigned done_cyc = 0;
    int          rd_seen = 0;

    typedef struct {
        int unsigned due;
        logic [9:0]  a;
    } rq_t;

    logic [31:0] mem [1024];
    rq_t         mq [$];
    logic [9:0]  exp_rd_q [$];
    logic [31:0] exp_dec_q [$];
    logic [9:0]  ea;
    logic [31:0] ed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [9:0] a, input logic last);
        return {last, 21'h0A5A5, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // In-order memory: read seen in cycle k returns in cycle k+lat.
    always @(posedge clk) begin
        #1;
        wvalid = 1'b0;
        wdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            wvalid = 1'b1;
            wdata  = mem[mq[0].a];
            void'(mq.pop_front());
        end
        if (rd) mq.push_back('{due: cyc + lat, a: rd_addr});
    end

    always @(negedge clk) begin
        if (rd) begin
            rd_seen++;
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_addr: unexpected read of %0h, none expected", rd_addr);
            end else begin
                ea = exp_rd_q.pop_front();
                chk("rd_addr", 32'(rd_addr), 32'(ea));
            end
        end
        if (dvalid && dready) begin
            if (exp_dec_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dec_data: unexpected word %0h, none expected", ddata);
            end else begin
                ed = exp_dec_q.pop_front();
                chk("dec_data", ddata, ed);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [9:0] base, input int n, input int last_idx);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            mem[a] = mk(a, i == last_idx);
        end
    endtask

    task automatic push_reads(input logic [9:0] base, input int n);
        for (int i = 0; i < n; i++) exp_rd_q.push_back(base + 10'(i));
    endtask

    task automatic push_dec(input logic [9:0] base, input int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            exp_dec_q.push_back(mk(a, i == n - 1));
        end
    endtask

    task automatic start_wu(input logic [9:0] a);
        tick();
        start      = 1'b1;
        start_addr = a;
        c0         = cyc;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt > base), 32'd1);
    endtask

    task automatic finish_wu(input string name, input int base, input int unsigned exp_done);
        repeat (4) tick();
        chk({name, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
        chk({name, "_dec_left"}, 32'(exp_dec_q.size()), 32'd0);
        chk({name, "_done_count"}, 32'(done_cnt - base), 32'd1);
        chk({name, "_done_cycle"}, done_cyc - c0, exp_done);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_read"}, 32'(rd), 32'd0);
        chk({name, "_addr"}, 32'(rd_addr), 32'd0);
        chk({name, "_dvalid"}, 32'(dvalid), 32'd0);
        chk({name, "_ddata"}, ddata, 32'd0);
    endtask

    initial begin
        int base;
        int rd0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #2 reset_poweron = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        reset_poweron = 1'b0;
        repeat (2) tick();

        // Basic WU, last flag on the fourth word, two speculative reads.
        lat = 1;
        dready = 1'b1;
        fill(10'h010, 6, 3);
        push_reads(10'h010, 6);
        push_dec(10'h010, 4);
        base = done_cnt;
        start_wu(10'h010);
        wait_done(base);
        finish_wu("basic", base, 8);

        // Backpressure: four credits, then reads resume one per pop.
        dready = 1'b0;
        fill(10'h100, 8, 5);
        push_reads(10'h100, 8);
        push_dec(10'h100, 6);
        base = done_cnt;
        rd0 = rd_seen;
        start_wu(10'h100);
        repeat (10) tick();
        chk("bp_reads_held", 32'(rd_seen - rd0), 32'd4);
        chk("bp_fifo_full_valid", 32'(dvalid), 32'd1);
        dready = 1'b1;
        wait_done(base);
        finish_wu("bp", base, 17);

        // Address wrap.
        fill(10'h3FE, 6, 3);
        push_reads(10'h3FE, 6);
        push_dec(10'h3FE, 4);
        base = done_cnt;
        start_wu(10'h3FE);
        wait_done(base);
        finish_wu("wrap", base, 8);

        // Abort with one word buffered and two reads outstanding.
        dready = 1'b0;
        fill(10'h050, 4, 99);
        push_reads(10'h050, 3);
        base = done_cnt;
        start_wu(10'h050);
        tick();
        tick();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_dvalid", 32'(dvalid), 32'd1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_post_dvalid", 32'(dvalid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        wait_done(base);
        finish_wu("abort", base, 5);

        // Second start while busy is ignored.
        dready = 1'b1;
        fill(10'h080, 6, 3);
        mem[10'h200] = mk(10'h200, 1'b1);
        push_reads(10'h080, 6);
        push_dec(10'h080, 4);
        base = done_cnt;
        start_wu(10'h080);
        tick();
        start      = 1'b1;
        start_addr = 10'h200;
        tick();
        start = 1'b0;
        wait_done(base);
        repeat (6) tick();
        finish_wu("restart", base, 8);

        // Reset with three words buffered, then a fresh WU.
        dready = 1'b0;
        fill(10'h0C0, 4, 99);
        push_reads(10'h0C0, 4);
        base = done_cnt;
        start_wu(10'h0C0);
        repeat (4) tick();
        reset_poweron = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        chk("midreset_rd_left", 32'(exp_rd_q.size()), 32'd0);
        repeat (2) tick();
        reset_poweron = 1'b0;
        repeat (3) tick();
        chk("midreset_no_done", 32'(done_cnt - base), 32'd0);
        dready = 1'b1;
        fill(10'h140, 4, 1);
        push_reads(10'h140, 4);
        push_dec(10'h140, 2);
        base = done_cnt;
        start_wu(10'h140);
        wait_done(base);
        finish_wu("post_reset", base, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, sequence incomplete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
